// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage. Runs the data-memory req/ack handshake,
// resolves branches and registers the writeback bundle.
// Ports: clk, rst_n (async, active-low); mem_* = EX/MEM bundle in;
//   dmem_req/we/addr/wdata out, dmem_rdata/ack in = data-memory port;
//   stall, branch_taken = comb. pipe control; wb_result/rd/reg_write =
//   registered writeback; mem_err = sticky access-timeout flag.
// Option: define MEM_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES
//   cycles without ack (load data forced to zero, mem_err set).
module mem_stage #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] mem_alu_result,
  input  logic [15:0] mem_rs2_data,
  input  logic [3:0]  mem_rd,
  input  logic [15:0] mem_branch_target,
  input  logic        mem_reg_write,
  input  logic        mem_mem_read,
  input  logic        mem_mem_write,
  input  logic        mem_mem_to_reg,
  input  logic        mem_branch,
  input  logic        mem_branch_ne,
  input  logic        mem_zero,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [15:0] dmem_addr,
  output logic [15:0] dmem_wdata,
  input  logic [15:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        stall,
  output logic        branch_taken,
  output logic [15:0] wb_result,
  output logic [3:0]  wb_rd,
  output logic        wb_reg_write,
  output logic        mem_err
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t      r_state;
  logic [15:0] r_rdata;
  logic [15:0] r_wb_result;
  logic [3:0]  r_wb_rd;
  logic        r_wb_reg_write;

  logic w_access;
  logic w_in_access;
  logic w_stall;
  logic w_take;

  assign w_access    = mem_mem_read | mem_mem_write;
  assign w_in_access = (r_state == S_ACCESS);
  // IDLE stalls on the cycle the access is seen; DONE releases the pipe.
  assign w_stall     = w_in_access |
                       ((r_state == S_IDLE) & w_access);
  assign w_take      = (mem_branch & mem_zero) |
                       (mem_branch_ne & ~mem_zero);

  assign stall        = w_stall;
  assign branch_taken = ~w_stall & w_take;
  assign dmem_req     = w_in_access;
  assign dmem_we      = w_in_access & mem_mem_write;
  assign dmem_addr    = mem_alu_result;
  assign dmem_wdata   = mem_rs2_data;
  assign wb_result    = r_wb_result;
  assign wb_rd        = r_wb_rd;
  assign wb_reg_write = r_wb_reg_write;

`ifdef MEM_TIMEOUT_EN
  localparam int CLOG = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CW   = (CLOG < 4) ? 4 : CLOG;

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_lim;
  logic          w_timeout;
  logic          r_err;

  // Last ackless ACCESS cycle: counter reaches TIMEOUT_CYCLES on this edge.
  assign w_cnt_lim = CW'(TIMEOUT_CYCLES - 1);
  assign w_timeout = w_in_access & ~dmem_ack & (r_cnt == w_cnt_lim);
  assign mem_err   = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) & w_access)
        r_cnt <= '0;
      else if (w_in_access & ~dmem_ack)
        r_cnt <= r_cnt + 1'b1;
      if (w_timeout)
        r_err <= 1'b1;
    end
  end
`else
  logic w_timeout;
  logic w_unused;

  assign w_timeout = 1'b0;
  assign mem_err   = 1'b0;
  assign w_unused  = ^{mem_branch_target, 1'(TIMEOUT_CYCLES)};
`endif

`ifdef MEM_TIMEOUT_EN
  logic w_unused_tgt;
  assign w_unused_tgt = ^mem_branch_target;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_rdata        <= '0;
      r_wb_result    <= '0;
      r_wb_rd        <= '0;
      r_wb_reg_write <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_access)
            r_state <= S_ACCESS;
        end
        S_ACCESS: begin
          if (dmem_ack) begin
            r_state <= S_DONE;
            r_rdata <= dmem_rdata;
          end else if (w_timeout) begin
            r_state <= S_DONE;
            r_rdata <= '0;
          end
        end
        S_DONE: begin
          // Held instruction is complete; never re-launch it.
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase

      if (w_stall) begin
        r_wb_reg_write <= 1'b0;
      end else begin
        r_wb_rd        <= mem_rd;
        r_wb_reg_write <= mem_reg_write & (mem_rd != 4'd0);
        r_wb_result    <= mem_mem_to_reg ? r_rdata : mem_alu_result;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized self-checking bench for mem_stage.
// Memory responder and reference model live in the bench.
module tb_mem_stage;

  localparam int TMO = 15;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] mem_alu_result;
  logic [15:0] mem_rs2_data;
  logic [3:0]  mem_rd;
  logic [15:0] mem_branch_target;
  logic        mem_reg_write;
  logic        mem_mem_read;
  logic        mem_mem_write;
  logic        mem_mem_to_reg;
  logic        mem_branch;
  logic        mem_branch_ne;
  logic        mem_zero;
  logic        dmem_req;
  logic        dmem_we;
  logic [15:0] dmem_addr;
  logic [15:0] dmem_wdata;
  logic [15:0] dmem_rdata;
  logic        dmem_ack;
  logic        stall;
  logic        branch_taken;
  logic [15:0] wb_result;
  logic [3:0]  wb_rd;
  logic        wb_reg_write;
  logic        mem_err;

  int n_err = 0;
  int n_chk = 0;

  // Reference state: last writeback and last data returned by memory.
  logic [15:0] m_res;
  logic [3:0]  m_rd;
  logic        m_we;
  logic [15:0] m_rdata;
  logic        m_err;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .mem_alu_result   (mem_alu_result),
    .mem_rs2_data     (mem_rs2_data),
    .mem_rd           (mem_rd),
    .mem_branch_target(mem_branch_target),
    .mem_reg_write    (mem_reg_write),
    .mem_mem_read     (mem_mem_read),
    .mem_mem_write    (mem_mem_write),
    .mem_mem_to_reg   (mem_mem_to_reg),
    .mem_branch       (mem_branch),
    .mem_branch_ne    (mem_branch_ne),
    .mem_zero         (mem_zero),
    .dmem_req         (dmem_req),
    .dmem_we          (dmem_we),
    .dmem_addr        (dmem_addr),
    .dmem_wdata       (dmem_wdata),
    .dmem_rdata       (dmem_rdata),
    .dmem_ack         (dmem_ack),
    .stall            (stall),
    .branch_taken     (branch_taken),
    .wb_result        (wb_result),
    .wb_rd            (wb_rd),
    .wb_reg_write     (wb_reg_write),
    .mem_err          (mem_err)
  );

  task automatic set_nop();
    mem_alu_result    = 16'h0;
    mem_rs2_data      = 16'h0;
    mem_rd            = 4'd0;
    mem_branch_target = 16'h0;
    mem_reg_write     = 1'b0;
    mem_mem_read      = 1'b0;
    mem_mem_write     = 1'b0;
    mem_mem_to_reg    = 1'b0;
    mem_branch        = 1'b0;
    mem_branch_ne     = 1'b0;
    mem_zero          = 1'b0;
  endtask

  task automatic model_reset();
    m_res   = 16'h0;
    m_rd    = 4'd0;
    m_we    = 1'b0;
    m_rdata = 16'h0;
    m_err   = 1'b0;
  endtask

  // One instruction through MEM. ack_on = ACCESS cycle carrying the
  // ack (1 = first); 0 = never ack (timeout build only).
  task automatic run_op(
    input logic        rw, mr, mw, m2r, br, bne, z,
    input logic [3:0]  rd,
    input logic [15:0] alu, st,
    input int          ack_on,
    input logic [15:0] rdat,
    input string       nm
  );
    logic is_mem;
    logic exp_bt;
    int   exp_st, exp_rq;
    int   nst, nreq, bad_we, bad_bub;
    bit   done;
    is_mem = mr | mw;
    exp_bt = (br & z) | (bne & ~z);
    if (!is_mem) begin
      exp_st = 0;
      exp_rq = 0;
    end else if (ack_on > 0) begin
      exp_rq = ack_on;
      exp_st = ack_on + 1;
    end else begin
      exp_rq = TMO;
      exp_st = TMO + 1;
    end

    mem_alu_result    = alu;
    mem_rs2_data      = st;
    mem_rd            = rd;
    mem_branch_target = 16'($urandom);
    mem_reg_write     = rw;
    mem_mem_read      = mr;
    mem_mem_write     = mw;
    mem_mem_to_reg    = m2r;
    mem_branch        = br;
    mem_branch_ne     = bne;
    mem_zero          = z;
    dmem_ack          = 1'b0;

    nst = 0; nreq = 0; bad_we = 0; bad_bub = 0; done = 0;
    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge clk);
      if (dmem_req) begin
        nreq++;
        if (dmem_we !== mw || dmem_addr !== alu ||
            dmem_wdata !== st)
          bad_we++;
      end
      if (stall) begin
        nst++;
        if (branch_taken !== 1'b0 || wb_result !== m_res ||
            wb_rd !== m_rd ||
            wb_reg_write !== ((nst > 1) ? 1'b0 : m_we))
          bad_bub++;
        if (dmem_req && nreq == ack_on) begin
          dmem_ack   = 1'b1;
          dmem_rdata = rdat;
        end else if (!dmem_req) begin
          // Stray ack outside ACCESS must be ignored.
          dmem_ack   = 1'b1;
          dmem_rdata = 16'($urandom);
        end else begin
          dmem_ack   = 1'b0;
          dmem_rdata = 16'($urandom);
        end
      end else begin
        done = 1;
      end
      if (!done) begin
        @(posedge clk);
        #1;
        dmem_ack = 1'b0;
      end
    end

    n_chk++;
    if (!done) begin
      n_err++;
      $display("FAIL %s stall_release: stall stuck after %0d cycles",
               nm, nst);
    end
    n_chk++;
    if (nst !== exp_st) begin
      n_err++;
      $display("FAIL %s stall_cycles: got %0d want %0d", nm, nst, exp_st);
    end
    n_chk++;
    if (nreq !== exp_rq) begin
      n_err++;
      $display("FAIL %s req_cycles: got %0d want %0d", nm, nreq, exp_rq);
    end
    n_chk++;
    if (bad_we !== 0) begin
      n_err++;
      $display("FAIL %s dmem_bus: %0d bad cycles want 0", nm, bad_we);
    end
    n_chk++;
    if (bad_bub !== 0) begin
      n_err++;
      $display("FAIL %s bubble: %0d bad cycles want 0", nm, bad_bub);
    end
    n_chk++;
    if (branch_taken !== exp_bt) begin
      n_err++;
      $display("FAIL %s branch_taken: got %b want %b",
               nm, branch_taken, exp_bt);
    end

    if (is_mem) begin
      m_rdata = (ack_on > 0) ? rdat : 16'h0;
      if (ack_on == 0) m_err = 1'b1;
    end
    m_rd  = rd;
    m_we  = rw & (rd != 4'd0);
    m_res = m2r ? m_rdata : alu;

    @(posedge clk);
    #1;
    set_nop();
    n_chk++;
    if (wb_result !== m_res) begin
      n_err++;
      $display("FAIL %s wb_result: got %h want %h", nm, wb_result, m_res);
    end
    n_chk++;
    if (wb_rd !== m_rd || wb_reg_write !== m_we) begin
      n_err++;
      $display("FAIL %s wb_ctl: got rd=%0d we=%b want rd=%0d we=%b",
               nm, wb_rd, wb_reg_write, m_rd, m_we);
    end
    n_chk++;
    if (mem_err !== m_err) begin
      n_err++;
      $display("FAIL %s mem_err: got %b want %b", nm, mem_err, m_err);
    end
  endtask

  task automatic test_reset();
    set_nop();
    rst_n      = 1'b0;
    dmem_ack   = 1'b0;
    dmem_rdata = 16'h0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if (wb_result !== 16'h0 || wb_rd !== 4'd0 || wb_reg_write !== 1'b0) begin
      n_err++;
      $display("FAIL reset_wb: got %h/%0d/%b want 0/0/0",
               wb_result, wb_rd, wb_reg_write);
    end
    n_chk++;
    if (dmem_req !== 1'b0 || stall !== 1'b0 || mem_err !== 1'b0 ||
        branch_taken !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ctl: req=%b stall=%b err=%b bt=%b want 0",
               dmem_req, stall, mem_err, branch_taken);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_alu();
    run_op(1, 0, 0, 0, 0, 0, 0, 4'd3, 16'h1234, 16'h0, 1, 16'h0, "alu");
  endtask

  task automatic test_load();
    run_op(1, 1, 0, 1, 0, 0, 0, 4'd5, 16'h0040, 16'h0, 3, 16'hBEEF,
           "load");
  endtask

  task automatic test_store();
    run_op(0, 0, 1, 0, 0, 0, 0, 4'd0, 16'h0010, 16'h00AA, 1, 16'h5A5A,
           "store");
    run_op(1, 1, 1, 1, 0, 0, 0, 4'd7, 16'h0022, 16'h1111, 2, 16'h3C3C,
           "rd_wr_both");
  endtask

  task automatic test_branch();
    run_op(0, 0, 0, 0, 1, 0, 1, 4'd0, 16'h0, 16'h0, 1, 16'h0, "beq_z1");
    run_op(0, 0, 0, 0, 0, 1, 1, 4'd0, 16'h0, 16'h0, 1, 16'h0, "bne_z1");
    run_op(0, 0, 0, 0, 0, 1, 0, 4'd0, 16'h0, 16'h0, 1, 16'h0, "bne_z0");
    run_op(0, 0, 0, 0, 1, 0, 0, 4'd0, 16'h0, 16'h0, 1, 16'h0, "beq_z0");
  endtask

  task automatic test_rd0();
    run_op(1, 0, 0, 0, 0, 0, 0, 4'd0, 16'hCAFE, 16'h0, 1, 16'h0, "rd0");
    run_op(1, 0, 0, 1, 0, 0, 0, 4'd9, 16'h0, 16'h0, 1, 16'h0, "m2r_alu");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++) begin
      int k;
      k = int'($urandom_range(0, 2));
      run_op($urandom_range(0, 1) == 1,
             k == 1, k == 2,
             $urandom_range(0, 1) == 1,
             $urandom_range(0, 1) == 1,
             $urandom_range(0, 1) == 1,
             $urandom_range(0, 1) == 1,
             4'($urandom), 16'($urandom), 16'($urandom),
             int'($urandom_range(1, 4)), 16'($urandom), "rand");
    end
  endtask

  task automatic test_reset_mid_access();
    mem_alu_result = 16'h0080;
    mem_mem_read   = 1'b1;
    mem_mem_to_reg = 1'b1;
    mem_rd         = 4'd2;
    mem_reg_write  = 1'b1;
    dmem_ack       = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_chk++;
    if (dmem_req !== 1'b1) begin
      n_err++;
      $display("FAIL rst_mid_pre: dmem_req got %b want 1", dmem_req);
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_chk++;
    if (dmem_req !== 1'b0 || wb_reg_write !== 1'b0 ||
        wb_result !== 16'h0 || mem_err !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid_drop: req=%b we=%b res=%h err=%b want 0",
               dmem_req, wb_reg_write, wb_result, mem_err);
    end
    @(negedge clk);
    set_nop();
    rst_n = 1'b1;
    #1;
    n_chk++;
    if (stall !== 1'b0 || dmem_req !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid_idle: stall=%b req=%b want 0/0",
               stall, dmem_req);
    end
    @(posedge clk);
    #1;
    run_op(1, 0, 0, 1, 0, 0, 0, 4'd4, 16'h0, 16'h0, 1, 16'h0,
           "post_rst_m2r");
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    run_op(1, 1, 0, 1, 0, 0, 0, 4'd6, 16'h0100, 16'h0, 0, 16'h0,
           "timeout");
    run_op(1, 0, 0, 0, 0, 0, 0, 4'd1, 16'h7777, 16'h0, 1, 16'h0,
           "after_to");
  endtask
`endif

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_branch();
    test_rd0();
    test_back_to_back();
    test_reset_mid_access();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
